// File: rtl/psum_acc_sram_pkg.sv
// Shared types, defaults and lane arithmetic for the partial-sum accumulate SRAM.
// Optional feature macro: PSUM_SAT_EN (saturating lane adds instead of wrap-around).
package psum_pkg;

  localparam int PSUM_DW    = 16;
  localparam int PSUM_LANES = 8;
  localparam int PSUM_DEPTH = 2048;

  typedef enum logic {ST_IDLE, ST_CLEAR} psum_clr_state_t;

  typedef struct packed {
    logic        sat;
    logic [31:0] val;
  } lane_res_t;

  // Operands arrive sign-extended to 32 bits; w is the real lane width (w <= 31).
  function automatic lane_res_t lane_add(input logic [31:0] a, input logic [31:0] b,
                                         input int w);
    lane_res_t res;
`ifdef PSUM_SAT_EN
    logic signed [32:0] s;
    logic signed [32:0] maxv;
    logic signed [32:0] minv;
    s    = $signed({a[31], a}) + $signed({b[31], b});
    maxv = (33'sd1 <<< (w - 1)) - 33'sd1;
    minv = -(33'sd1 <<< (w - 1));
    res.sat = 1'b0;
    res.val = s[31:0];
    if (s > maxv) begin
      res.val = maxv[31:0];
      res.sat = 1'b1;
    end else if (s < minv) begin
      res.val = minv[31:0];
      res.sat = 1'b1;
    end
`else
    res.sat = 1'b0;
    res.val = (a + b) & ((32'd1 << w) - 32'd1);
`endif
    return res;
  endfunction

endpackage

// File: rtl/psum_acc_sram_if.sv
// Request/response bundle of the partial-sum SRAM (sat_flag present only with PSUM_SAT_EN).
interface psum_acc_sram_if #(
  parameter int DW    = 16,
  parameter int LANES = 8,
  parameter int AW    = 11
) ();
  logic                  CEN;
  logic                  REN;
  logic                  WEN;
  logic                  ACC;
  logic                  clr_req;
  logic [AW-1:0]         A;
  logic [LANES*DW-1:0]   D;
  logic [LANES*DW-1:0]   Q;
  logic                  busy;
`ifdef PSUM_SAT_EN
  logic                  sat_flag;
`endif

  modport master (
    output CEN, REN, WEN, ACC, clr_req, A, D,
`ifdef PSUM_SAT_EN
    input  sat_flag,
`endif
    input  Q, busy
  );

  modport slave (
    input  CEN, REN, WEN, ACC, clr_req, A, D,
`ifdef PSUM_SAT_EN
    output sat_flag,
`endif
    output Q, busy
  );
endinterface

// File: rtl/psum_lane_adder.sv
// LANES independent DW-bit adders (wrap, or saturate under PSUM_SAT_EN); purely combinational.
module psum_lane_adder
  import psum_pkg::*;
#(
  parameter int DW    = PSUM_DW,
  parameter int LANES = PSUM_LANES
) (
  input  logic [LANES*DW-1:0] a,
  input  logic [LANES*DW-1:0] b,
  output logic [LANES*DW-1:0] sum,
  output logic                sat_any
);

  logic [LANES-1:0] sat_vec;
  logic [LANES-1:0] unused_hi;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      lane_res_t r;
      assign r = lane_add(32'($signed(a[gi*DW +: DW])), 32'($signed(b[gi*DW +: DW])), DW);
      assign sum[gi*DW +: DW] = r.val[DW-1:0];
      assign sat_vec[gi]      = r.sat;
      assign unused_hi[gi]    = ^r.val[31:DW];
    end
  endgenerate

  assign sat_any = |sat_vec;

endmodule

// File: rtl/psum_acc_sram.sv
// Partial-sum SRAM with overwrite / two-stage accumulate writes, read forwarding and a clear sweep.
// Optional feature macro: PSUM_SAT_EN (saturating accumulate plus sat_flag output).
module psum_acc_sram
  import psum_pkg::*;
#(
  parameter int DW    = PSUM_DW,
  parameter int LANES = PSUM_LANES,
  parameter int DEPTH = PSUM_DEPTH
) (
  input  logic           CLK,
  input  logic           reset,
  psum_acc_sram_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int W  = LANES * DW;

  logic [W-1:0] mem [DEPTH];

  psum_clr_state_t state_reg, state_next;
  logic [AW-1:0]   clr_ctr_reg, clr_ctr_next;
  logic            acc_v_reg;
  logic [AW-1:0]   acc_a_reg;
  logic [W-1:0]    acc_d_reg;
  logic [W-1:0]    q_reg;
  logic [W-1:0]    acc_sum;
  logic            sat_any;
  logic            busy_w, req_ok, clr_go, rd_go, wr_go;

  assign busy_w = (state_reg == ST_CLEAR);
  assign req_ok = !bus.CEN && !busy_w;
  // A clear request swallows any read/write presented alongside it.
  assign clr_go = req_ok && bus.clr_req;
  assign rd_go  = req_ok && !bus.clr_req && bus.REN;
  assign wr_go  = req_ok && !bus.clr_req && bus.WEN;

  psum_lane_adder #(.DW(DW), .LANES(LANES)) u_adder (
    .a       (mem[acc_a_reg]),
    .b       (acc_d_reg),
    .sum     (acc_sum),
    .sat_any (sat_any)
  );

  always_comb begin
    state_next   = state_reg;
    clr_ctr_next = clr_ctr_reg;
    case (state_reg)
      ST_IDLE: begin
        if (clr_go) begin
          state_next   = ST_CLEAR;
          clr_ctr_next = '0;
        end
      end
      ST_CLEAR: begin
        if (clr_ctr_reg == AW'(DEPTH - 1)) begin
          state_next   = ST_IDLE;
          clr_ctr_next = '0;
        end else begin
          clr_ctr_next = clr_ctr_reg + 1'b1;
        end
      end
      default: begin
        state_next   = ST_IDLE;
        clr_ctr_next = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_CLEAR;
      clr_ctr_reg <= '0;
      acc_v_reg   <= 1'b0;
      acc_a_reg   <= '0;
      acc_d_reg   <= '0;
      q_reg       <= '0;
    end else begin
      state_reg   <= state_next;
      clr_ctr_reg <= clr_ctr_next;
      acc_v_reg   <= wr_go && bus.ACC;
      if (wr_go && bus.ACC) begin
        acc_a_reg <= bus.A;
        acc_d_reg <= bus.D;
      end
      // Reads see the sum committing at this same edge.
      if (rd_go)
        q_reg <= (acc_v_reg && acc_a_reg == bus.A) ? acc_sum : mem[bus.A];
    end
  end

  // Later assignments win: accumulate commit first, then an overwrite to the same word.
  always_ff @(posedge CLK) begin
    if (state_reg == ST_CLEAR)
      mem[clr_ctr_reg] <= '0;
    if (acc_v_reg)
      mem[acc_a_reg] <= acc_sum;
    if (wr_go && !bus.ACC)
      mem[bus.A] <= bus.D;
  end

`ifdef PSUM_SAT_EN
  logic sat_flag_reg;
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) sat_flag_reg <= 1'b0;
    else       sat_flag_reg <= acc_v_reg && sat_any;
  end
  assign bus.sat_flag = sat_flag_reg;
`else
  logic unused_sat;
  assign unused_sat = sat_any;
`endif

  assign bus.Q    = q_reg;
  assign bus.busy = busy_w;

endmodule

// File: tb/tb_psum_acc_sram.sv
// Directed self-checking bench for psum_acc_sram (honours PSUM_SAT_EN when defined).
module tb_psum_acc_sram;
  localparam int DW = 16;
  localparam int LANES = 8;
  localparam int AW = 11;
  localparam int W = DW * LANES;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;

  psum_acc_sram_if #(.DW(DW), .LANES(LANES), .AW(AW)) bus ();

  psum_acc_sram dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  function automatic logic [W-1:0] fill(input logic [DW-1:0] v);
    logic [W-1:0] w;
    for (int i = 0; i < LANES; i++) w[i*DW +: DW] = v;
    return w;
  endfunction

  task automatic idle_inputs();
    bus.CEN = 1'b1; bus.REN = 1'b0; bus.WEN = 1'b0; bus.ACC = 1'b0;
    bus.clr_req = 1'b0; bus.A = '0; bus.D = '0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [W-1:0] q);
    bus.CEN = 1'b0; bus.REN = 1'b1; bus.A = a;
    @(negedge CLK);
    q = bus.Q;
    idle_inputs();
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d, input logic acc);
    bus.CEN = 1'b0; bus.WEN = 1'b1; bus.ACC = acc; bus.A = a; bus.D = d;
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic count_busy(output int n, input bit pulse_clr);
    n = 0;
    while (bus.busy === 1'b1 && n < 3000) begin
      n++;
      if (pulse_clr && n == 1000) begin
        bus.CEN = 1'b0; bus.clr_req = 1'b1;
      end
      @(negedge CLK);
      bus.CEN = 1'b1; bus.clr_req = 1'b0;
    end
  endtask

  task automatic test_reset();
    int n;
    logic [W-1:0] q;
    logic [AW-1:0] addrs [3];
    addrs[0] = 11'd0; addrs[1] = 11'd1023; addrs[2] = 11'd2047;
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (bus.Q !== '0) begin n_bad++; $display("FAIL reset_q: got %h expected 0", bus.Q); end
    n_cmp++;
    if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy: got %b expected 1", bus.busy); end
    reset = 1'b0;
    count_busy(n, 1'b0);
    n_cmp++;
    if (n != 2048) begin n_bad++; $display("FAIL init_sweep_len: got %0d expected 2048", n); end
    $display("init sweep: busy cycles=%0d", n);
    for (int i = 0; i < 3; i++) begin
      do_read(addrs[i], q);
      n_cmp++;
      if (q !== '0) begin n_bad++; $display("FAIL init_read[%0d]: got %h expected 0", addrs[i], q); end
      $display("read A=%0d Q=%h", addrs[i], q);
    end
  endtask

  task automatic test_overwrite();
    logic [W-1:0] d, q;
    for (int i = 0; i < LANES; i++) d[i*DW +: DW] = DW'(i + 1);
    do_write(11'd5, d, 1'b0);
    do_read(11'd5, q);
    n_cmp++;
    if (q !== d) begin n_bad++; $display("FAIL overwrite_read: got %h expected %h", q, d); end
    $display("overwrite A=5 read Q=%h", q);
    @(negedge CLK);
    n_cmp++;
    if (bus.Q !== d) begin n_bad++; $display("FAIL q_hold: got %h expected %h", bus.Q, d); end
    bus.CEN = 1'b1; bus.REN = 1'b1; bus.A = 11'd0;
    @(negedge CLK);
    idle_inputs();
    n_cmp++;
    if (bus.Q !== d) begin n_bad++; $display("FAIL cen_ignore: got %h expected %h", bus.Q, d); end
    $display("CEN high read ignored Q=%h", bus.Q);
  endtask

  task automatic test_accumulate();
    logic [W-1:0] q;
    repeat (3) do_write(11'd7, fill(16'd3), 1'b1);
    do_read(11'd7, q);
    n_cmp++;
    if (q !== fill(16'd9)) begin n_bad++; $display("FAIL acc_b2b: got %h expected %h", q, fill(16'd9)); end
    $display("3x acc A=7 read Q=%h", q);
  endtask

  task automatic test_hazards();
    logic [W-1:0] q;
    do_write(11'd9, fill(16'd4), 1'b1);
    do_write(11'd9, fill(16'd100), 1'b0);
    do_read(11'd9, q);
    n_cmp++;
    if (q !== fill(16'd100)) begin n_bad++; $display("FAIL acc_then_ovw: got %h expected %h", q, fill(16'd100)); end
    $display("acc then overwrite A=9 Q=%h", q);
    do_write(11'd11, fill(16'd5), 1'b1);
    bus.CEN = 1'b0; bus.REN = 1'b1; bus.WEN = 1'b1; bus.ACC = 1'b0;
    bus.A = 11'd11; bus.D = fill(16'd50);
    @(negedge CLK);
    idle_inputs();
    n_cmp++;
    if (bus.Q !== fill(16'd5)) begin n_bad++; $display("FAIL fwd_read: got %h expected %h", bus.Q, fill(16'd5)); end
    $display("forwarded read A=11 Q=%h", bus.Q);
    do_read(11'd11, q);
    n_cmp++;
    if (q !== fill(16'd50)) begin n_bad++; $display("FAIL ovw_after_fwd: got %h expected %h", q, fill(16'd50)); end
    $display("read A=11 after overwrite Q=%h", q);
  endtask

  task automatic test_lane_limits(output logic [W-1:0] last_q);
    logic [W-1:0] init, dv, exp_w, q;
    init = '0; dv = fill(16'd1); exp_w = fill(16'd1);
    init[0*DW +: DW] = 16'h7FFF;
    init[1*DW +: DW] = 16'hFFFF;
    init[2*DW +: DW] = 16'h0002;
    init[3*DW +: DW] = 16'h8000;
    dv[3*DW +: DW]   = 16'hFFFF;
`ifdef PSUM_SAT_EN
    exp_w[0*DW +: DW] = 16'h7FFF;
    exp_w[3*DW +: DW] = 16'h8000;
`else
    exp_w[0*DW +: DW] = 16'h8000;
    exp_w[3*DW +: DW] = 16'h7FFF;
`endif
    exp_w[1*DW +: DW] = 16'h0000;
    exp_w[2*DW +: DW] = 16'h0003;
    do_write(11'd20, init, 1'b0);
    do_write(11'd20, dv, 1'b1);
    do_read(11'd20, q);
    n_cmp++;
    if (q !== exp_w) begin n_bad++; $display("FAIL limit_fwd: got %h expected %h", q, exp_w); end
    $display("lane limits forwarded Q=%h", q);
`ifdef PSUM_SAT_EN
    n_cmp++;
    if (bus.sat_flag !== 1'b1) begin n_bad++; $display("FAIL sat_flag_set: got %b expected 1", bus.sat_flag); end
`endif
    do_read(11'd20, q);
    n_cmp++;
    if (q !== exp_w) begin n_bad++; $display("FAIL limit_mem: got %h expected %h", q, exp_w); end
    $display("lane limits stored Q=%h", q);
`ifdef PSUM_SAT_EN
    n_cmp++;
    if (bus.sat_flag !== 1'b0) begin n_bad++; $display("FAIL sat_flag_pulse: got %b expected 0", bus.sat_flag); end
`endif
    last_q = q;
  endtask

  task automatic test_clear(input logic [W-1:0] prev_q);
    int n;
    logic [W-1:0] q;
    repeat (10) @(negedge CLK);
    bus.CEN = 1'b0; bus.clr_req = 1'b1; bus.REN = 1'b1; bus.A = 11'd5;
    @(negedge CLK);
    idle_inputs();
    n_cmp++;
    if (bus.Q !== prev_q) begin n_bad++; $display("FAIL clr_drops_read: got %h expected %h", bus.Q, prev_q); end
    n_cmp++;
    if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL clr_busy: got %b expected 1", bus.busy); end
    $display("clr_req with REN: busy=%b Q=%h", bus.busy, bus.Q);
    repeat (499) @(negedge CLK);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.Q !== '0) begin n_bad++; $display("FAIL midsweep_reset_q: got %h expected 0", bus.Q); end
    n_cmp++;
    if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL midsweep_reset_busy: got %b expected 1", bus.busy); end
    @(negedge CLK);
    reset = 1'b0;
    count_busy(n, 1'b1);
    n_cmp++;
    if (n != 2048) begin n_bad++; $display("FAIL restart_sweep_len: got %0d expected 2048", n); end
    $display("restarted sweep: busy cycles=%0d", n);
    do_read(11'd5, q);
    n_cmp++;
    if (q !== '0) begin n_bad++; $display("FAIL cleared_a5: got %h expected 0", q); end
    do_read(11'd9, q);
    n_cmp++;
    if (q !== '0) begin n_bad++; $display("FAIL cleared_a9: got %h expected 0", q); end
    $display("post-clear reads A=5,9 Q=%h", q);
  endtask

  initial begin
    logic [W-1:0] last_q;
    test_reset();
    test_overwrite();
    test_accumulate();
    test_hazards();
    test_lane_limits(last_q);
    test_clear(last_q);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
